// File: rtl/mdu_if.sv
// Handshake/data bundle between the execute stage and the M-extension sequencer.
interface mdu_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_addr_in;
  logic            flush;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_addr_out;

  modport master (
    output start, funct3, rs1_data, rs2_data, rd_addr_in, flush,
    input  stall, done, result, rd_addr_out
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, rd_addr_in, flush,
    output stall, done, result, rd_addr_out
  );
endinterface

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, sign fix-up applied on completion.
module mdu_seq #(
  parameter int XLEN = 32
) (
  input logic  clk,
  input logic  rst_n,
  mdu_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [2:0]      op_r;
  logic [XLEN-1:0] hi_r, lo_r, b_r;
  logic            neg_q_r, neg_rem_r;
  logic [4:0]      rd_r, rd_out_r;
  logic [XLEN-1:0] result_r;
  logic            done_r;

  logic            accept_s, s1_signed_s, s2_signed_s, a_neg_s, b_neg_s;
  logic            div_zero_s, div_ovf_s;
  logic [XLEN-1:0] a_mag_s, b_mag_s, special_s;
  logic [XLEN:0]   mul_sum_s, div_sh_s, div_diff_s;
  logic            div_ge_s;
  logic [XLEN-1:0] nxt_hi_s, nxt_lo_s, quot_s, rem_s, final_s;
  logic [2*XLEN-1:0] prod_s, prod_fix_s;

  // Decode operand signedness, magnitudes and the divide special cases.
  always_comb begin
    accept_s    = bus.start && !bus.flush;
    s1_signed_s = bus.funct3[2] ? !bus.funct3[0]
                                : (bus.funct3[1:0] == 2'b01 || bus.funct3[1:0] == 2'b10);
    s2_signed_s = bus.funct3[2] ? !bus.funct3[0] : (bus.funct3[1:0] == 2'b01);
    a_neg_s     = s1_signed_s && bus.rs1_data[XLEN-1];
    b_neg_s     = s2_signed_s && bus.rs2_data[XLEN-1];
    a_mag_s     = a_neg_s ? (ZERO - bus.rs1_data) : bus.rs1_data;
    b_mag_s     = b_neg_s ? (ZERO - bus.rs2_data) : bus.rs2_data;
    div_zero_s  = bus.funct3[2] && (bus.rs2_data == ZERO);
    div_ovf_s   = bus.funct3[2] && !bus.funct3[0] &&
                  (bus.rs1_data == MIN_NEG) && (bus.rs2_data == ONES);
    if (div_zero_s) begin
      special_s = bus.funct3[1] ? bus.rs1_data : ONES;
    end else begin
      special_s = bus.funct3[1] ? ZERO : MIN_NEG;
    end
  end

  // One shift-add or restoring-subtract step, plus the sign-corrected result.
  always_comb begin
    mul_sum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {(XLEN+1){1'b0}});
    div_sh_s   = {hi_r, lo_r[XLEN-1]};
    div_diff_s = div_sh_s - {1'b0, b_r};
    div_ge_s   = !div_diff_s[XLEN];
    if (op_r[2]) begin
      nxt_hi_s = div_ge_s ? div_diff_s[XLEN-1:0] : div_sh_s[XLEN-1:0];
      nxt_lo_s = {lo_r[XLEN-2:0], div_ge_s};
    end else begin
      nxt_hi_s = mul_sum_s[XLEN:1];
      nxt_lo_s = {mul_sum_s[0], lo_r[XLEN-1:1]};
    end
    prod_s     = {nxt_hi_s, nxt_lo_s};
    prod_fix_s = neg_q_r ? ({(2*XLEN){1'b0}} - prod_s) : prod_s;
    quot_s     = neg_q_r ? (ZERO - nxt_lo_s) : nxt_lo_s;
    rem_s      = neg_rem_r ? (ZERO - nxt_hi_s) : nxt_hi_s;
    case (op_r)
      3'b000:                 final_s = prod_fix_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_s = prod_fix_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_s = quot_s;
      3'b110, 3'b111:         final_s = rem_s;
      default:                final_s = ZERO;
    endcase
  end

  // Sequencer FSM: accept, iterate XLEN times, publish result for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      op_r      <= 3'b000;
      hi_r      <= ZERO;
      lo_r      <= ZERO;
      b_r       <= ZERO;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      rd_r      <= 5'd0;
      rd_out_r  <= 5'd0;
      result_r  <= ZERO;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r      <= bus.funct3;
            rd_r      <= bus.rd_addr_in;
            cnt_r     <= CW'(XLEN - 1);
            hi_r      <= ZERO;
            lo_r      <= bus.funct3[2] ? a_mag_s : b_mag_s;
            b_r       <= bus.funct3[2] ? b_mag_s : a_mag_s;
            // Low half of MUL is sign-agnostic, so never negate it.
            neg_q_r   <= (bus.funct3 == 3'b000) ? 1'b0 : (a_neg_s ^ b_neg_s);
            neg_rem_r <= a_neg_s;
            if (div_zero_s || div_ovf_s) begin
              result_r <= special_s;
              rd_out_r <= bus.rd_addr_in;
              done_r   <= 1'b1;
              state_r  <= DONE;
            end else begin
              state_r  <= CALC;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          if (bus.flush) begin
            state_r <= IDLE;
          end else begin
            hi_r <= nxt_hi_s;
            lo_r <= nxt_lo_s;
            if (cnt_r == {CW{1'b0}}) begin
              result_r <= final_s;
              rd_out_r <= rd_r;
              done_r   <= 1'b1;
              state_r  <= DONE;
            end else begin
              cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
            end
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // A flush in the DONE cycle suppresses the pulse; stall holds upstream while busy.
  assign bus.done        = done_r && !bus.flush;
  assign bus.stall       = (state_r == CALC) || ((state_r == IDLE) && accept_s);
  assign bus.result      = result_r;
  assign bus.rd_addr_out = rd_out_r;
endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: directed ops push expectations, a monitor
// pops and compares result, rd and completion cycle on every done pulse.
module tb_mdu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  mdu_if #(.XLEN(32)) bus ();
  mdu_seq #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", bus.result, e.res);
        chk("rd_addr_out", {27'd0, bus.rd_addr_out}, {27'd0, e.rd});
        chk("done_cycle", cyc, e.due);
        chk("stall_in_done", {31'd0, bus.stall}, 32'd0);
      end
    end
  end

  // Present one op for a single cycle starting at posedge+1.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res, input int lat,
                       input bit push);
    bus.start = 1'b1; bus.funct3 = f; bus.rs1_data = a; bus.rs2_data = b;
    bus.rd_addr_in = rd;
    if (push) exp_q.push_back('{res, rd, cyc + lat});
    #1;
    chk("stall_on_start", {31'd0, bus.stall}, 32'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Wait (bounded) until every expected completion was seen.
  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("timeout", 32'd1, 32'd0);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int c0;
    bus.start = 1'b0; bus.funct3 = 3'b000; bus.rs1_data = 32'd0; bus.rs2_data = 32'd0;
    bus.rd_addr_in = 5'd0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", bus.result, 32'd0);
    chk("reset_rd", {27'd0, bus.rd_addr_out}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_stall", {31'd0, bus.stall}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Multiplies and normal divides: done 33 cycles after start.
    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33, 1'b1);
    #1; chk("stall_mid_calc", {31'd0, bus.stall}, 32'd1);
    wait_idle();
    issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 33, 1'b1); wait_idle();
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 33, 1'b1); wait_idle();
    issue(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF, 33, 1'b1); wait_idle();
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 33, 1'b1); wait_idle();
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 33, 1'b1); wait_idle();
    issue(3'b101, 32'd100, 32'd7, 5'd11, 32'd14, 33, 1'b1); wait_idle();
    issue(3'b111, 32'd100, 32'd7, 5'd12, 32'd2, 33, 1'b1); wait_idle();

    // Special divide cases complete one cycle after start.
    issue(3'b101, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 1, 1'b1); wait_idle();
    issue(3'b111, 32'd5, 32'd0, 5'd14, 32'd5, 1, 1'b1); wait_idle();
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1, 1'b1); wait_idle();
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 1, 1'b1); wait_idle();

    // start together with flush in IDLE is not accepted.
    bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'b000;
    bus.rs1_data = 32'd3; bus.rs2_data = 32'd3; bus.rd_addr_in = 5'd1;
    #1; chk("stall_start_flush", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;

    // Flush at cycle 10 of a MUL: no done, result kept, restart at 11 ends at 44.
    c0 = cyc;
    issue(3'b000, 32'd3, 32'd4, 5'd17, 32'd12, 33, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    chk("flush_cycle", cyc - c0, 32'd10);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_idle_stall", {31'd0, bus.stall}, 32'd0);
    chk("flush_result_kept", bus.result, 32'd0);
    issue(3'b000, 32'd6, 32'd7, 5'd18, 32'd42, 33, 1'b1);
    wait_idle();

    // Asynchronous reset mid-CALC clears outputs at once; no done follows.
    issue(3'b101, 32'd50, 32'd5, 5'd19, 32'd10, 33, 1'b0);
    repeat (14) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_result", bus.result, 32'd0);
    chk("arst_rd", {27'd0, bus.rd_addr_out}, 32'd0);
    chk("arst_done", {31'd0, bus.done}, 32'd0);
    chk("arst_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
    issue(3'b101, 32'd9, 32'd3, 5'd20, 32'd3, 33, 1'b1);
    wait_idle();
    repeat (5) begin @(posedge clk); #1; end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative RV32M multiply/divide sequencer beside the integer execute unit.
- Accepts one M-extension operation from the execute stage and holds the pipeline with a stall while it runs a radix-2 shift-add multiply or restoring divide over XLEN cycles.
- Returns the result with rd address for the memory stage; its result is muxed onto the stage data path when done is high.
- Flush from the branch/jump unit aborts an operation in flight.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  execute stage presents a valid M-extension op this cycle
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_data  input  XLEN  operand 1 (multiplicand/dividend)
- rs2_data  input  XLEN  operand 2 (multiplier/divisor)
- rd_addr_in  input  5  destination register
- flush  input  1  abort current operation, discard result
- stall  output  1  hold upstream stages and execute inputs
- done  output  1  one-cycle pulse, result valid
- result  output  XLEN  operation result
- rd_addr_out  output  5  destination register of completed op

Behaviour:
- States IDLE, CALC, DONE.
- Reset (rst_n low, async): state IDLE, counter 0, result 0, rd_addr_out 0, done 0; all internal accumulators 0. Reset mid-CALC discards the operation with no done.
- IDLE:
  - start=1 and flush=0 at edge ending cycle T: operands, funct3 and rd_addr latch, and counter loads XLEN-1.
  - Next state is CALC, or DONE for a special divide case.
- Special divide cases skip CALC, so DONE is in cycle T+1:
  - divisor 0: DIV/DIVU quotient all-ones (0xFFFFFFFF); REM/REMU result is the dividend.
  - DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- CALC:
  - One iteration per cycle; counter decrements.
  - After the iteration with counter 0, go to DONE. Normal ops have done in cycle T+XLEN+1 (T+33 for XLEN=32).
- Multiply:
  - Operands are sign-extended per funct3: MULH both signed, MULHSU rs1 signed/rs2 unsigned, MULHU both unsigned.
  - 2*XLEN product; MUL returns the low half, MULH* the high half.
- Divide:
  - Signed ops divide magnitudes, then negate at completion: quotient if operand signs differ, remainder if the dividend is negative.
  - DIVU/REMU are unsigned.
- DONE: done=1 for exactly one cycle; result and rd_addr_out are valid and held until the next completion. Next state is IDLE.
- start while in CALC/DONE is ignored; the pipeline must not present a new op while stall=1.
- stall = (state==CALC) or (state==IDLE and start and not flush). This is combinational from start; stall=0 in DONE so the pipeline advances in the same cycle done is sampled.
- Back-to-back ops: start in the cycle after DONE is accepted normally, with no bubble beyond the IDLE cycle.
- flush:
  - Any state → IDLE at next edge, with done forced 0 that cycle.
  - flush with start in IDLE: op not accepted.
  - flush in DONE: done suppressed.
  - result register unchanged by flush.
- Counter width clog2(XLEN); no wrap: counter is only reloaded from IDLE.

Test Plan:
- MUL 7×(-3): start at cycle 0 → stall high cycles 0–32; done at cycle 33; result 0xFFFFFFEB; rd_addr_out matches the input.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; each done exactly 33 cycles after start.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, done at cycle 1. DIV 0x80000000/-1 → 0x80000000 and REM → 0, done at cycle 1.
- flush at cycle 10 of a MUL → IDLE at cycle 11; no done pulse; result keeps its previous value. A new start at cycle 11 completes normally at cycle 44.
- rst_n asserted asynchronously mid-CALC (cycle 15): outputs 0 immediately, no done. After release, a DIVU 9/3 runs cleanly → 3.
